// File: rtl/arb_pkg.sv
// Shared types and constants for the parametrised arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    // Width of the optional hold counter.
    localparam int ARB_HOLD_W = 8;

endpackage

// File: rtl/arb_prio_pick.sv
// Lowest-index-first picker: one-hot grant, its index, and an any-request flag.
// Latency: purely combinational.
// Backpressure: none.
// Ports: req (N-bit request), onehot (lowest set bit), idx (its index), any (|req).
module arb_prio_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = |req;
        // Walk from the top down so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IW'(i);
            end
        end
    end

endmodule

// File: rtl/arb_param.sv
// N-requester non-preemptive arbiter, fixed-priority (bit 0 highest) or round-robin.
// Latency: grant registered, visible one cycle after the request is sampled; owner handover has no idle bubble.
// Backpressure: owner keeps the grant until it drops its request (or, with ARB_MAX_HOLD_EN, until MAX_HOLD cycles elapse while others wait).
// Ports: clk, resetn (async active-low), r (requests), g (one-hot-or-zero grant),
//        gnt_valid (|g), gnt_idx (owner index, 0 when idle). All outputs registered.
// Optional macro: ARB_MAX_HOLD_EN enables the hold-limit counter.
module arb_param
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MODE     = 0,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [N_REQ-1:0]         r,
    output logic [N_REQ-1:0]         g,
    output logic                     gnt_valid,
    output logic [$clog2(N_REQ)-1:0] gnt_idx
);

    localparam int IW = $clog2(N_REQ);
    localparam bit RR = (MODE == int'(ARB_RR));

    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
        $error("arb_param: N_REQ out of range");
    end
    if (MAX_HOLD < 1 || MAX_HOLD >= (1 << ARB_HOLD_W)) begin : g_bad_hold
        $error("arb_param: MAX_HOLD out of range");
    end

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] g_d;
    logic [IW-1:0]    idx_d;
    logic [IW-1:0]    ptr_q, ptr_d;

    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] ptr_mask;
    logic [N_REQ-1:0] m_oh, u_oh, win_oh;
    logic [IW-1:0]    m_idx, u_idx, win_idx;
    logic             m_any, u_any, win_any;
    logic             owner_req;
    logic             force_rel;
    logic             do_arb;

    // Masking the current owner out of the candidates matters only for a
    // forced release; on a voluntary release its request is already low.
    assign cand      = r & ~g;
    assign owner_req = |(r & g);

    always_comb begin
        ptr_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ptr_mask[i] = (i >= int'(ptr_q));
        end
    end

    arb_prio_pick #(.N(N_REQ)) u_pick_masked (
        .req    (cand & ptr_mask),
        .onehot (m_oh),
        .idx    (m_idx),
        .any    (m_any)
    );

    arb_prio_pick #(.N(N_REQ)) u_pick_full (
        .req    (cand),
        .onehot (u_oh),
        .idx    (u_idx),
        .any    (u_any)
    );

    // Round-robin: prefer indices at or above ptr, else wrap to the lowest.
    always_comb begin
        if (RR && m_any) begin
            win_oh  = m_oh;
            win_idx = m_idx;
        end else begin
            win_oh  = u_oh;
            win_idx = u_idx;
        end
        win_any = u_any;
    end

`ifdef ARB_MAX_HOLD_EN
    localparam logic [ARB_HOLD_W:0] HOLD_LIM = (ARB_HOLD_W + 1)'(MAX_HOLD);

    logic [ARB_HOLD_W-1:0] hold_q, hold_d;
    logic [ARB_HOLD_W:0]   hold_inc;
    logic                  others_wait;

    assign others_wait = |cand;
    assign hold_inc    = {1'b0, hold_q} + (ARB_HOLD_W + 1)'(1);

    // The cycle now ending is a hold cycle; if it brings the count to the
    // limit, this edge hands the grant over.
    assign force_rel = (state_q == ARB_OWNED) && owner_req && others_wait
                       && (hold_inc >= HOLD_LIM);

    always_comb begin
        hold_d = hold_q;
        if (do_arb && win_any) begin
            hold_d = '0;
        end else if (state_q == ARB_OWNED && owner_req && others_wait) begin
            hold_d = hold_inc[ARB_HOLD_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        g_d     = g;
        idx_d   = gnt_idx;
        ptr_d   = ptr_q;
        do_arb  = 1'b0;

        case (state_q)
            ARB_IDLE:  do_arb = 1'b1;
            ARB_OWNED: do_arb = !owner_req || force_rel;
            default:   do_arb = 1'b1;
        endcase

        if (do_arb) begin
            if (win_any) begin
                state_d = ARB_OWNED;
                g_d     = win_oh;
                idx_d   = win_idx;
                ptr_d   = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + IW'(1);
            end else begin
                state_d = ARB_IDLE;
                g_d     = '0;
                idx_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ARB_IDLE;
            g         <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            g         <= g_d;
            gnt_valid <= (state_d == ARB_OWNED);
            gnt_idx   <= idx_d;
            ptr_q     <= ptr_d;
        end
    end

endmodule

// File: tb/tb_arb_param.sv
// Bench for arb_param: three instances (N=3 fixed, N=4 round-robin, N=4 round-robin with MAX_HOLD=4).
// Stimulus pushes the expected grant into a per-instance queue; monitors pop and compare after each edge.
// Grant-hold expectations for the third instance depend on ARB_MAX_HOLD_EN.
module tb_arb_param;

    logic clk;
    logic resetn;

    logic [2:0] ra, ga;
    logic       va;
    logic [1:0] ia;
    logic [3:0] rb, gb;
    logic       vb;
    logic [1:0] ib;
    logic [3:0] rc, gc;
    logic       vc;
    logic [1:0] ic;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] qa[$], qb[$], qc[$];
    string      ta[$], tbq[$], tc[$];

    arb_param #(.N_REQ(3), .MODE(0), .MAX_HOLD(8)) dut_a (
        .clk(clk), .resetn(resetn), .r(ra), .g(ga), .gnt_valid(va), .gnt_idx(ia)
    );
    arb_param #(.N_REQ(4), .MODE(1), .MAX_HOLD(8)) dut_b (
        .clk(clk), .resetn(resetn), .r(rb), .g(gb), .gnt_valid(vb), .gnt_idx(ib)
    );
    arb_param #(.N_REQ(4), .MODE(1), .MAX_HOLD(4)) dut_c (
        .clk(clk), .resetn(resetn), .r(rc), .g(gc), .gnt_valid(vc), .gnt_idx(ic)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] ag, input logic av,
                         input logic [3:0] ai, input logic [3:0] eg);
        logic       ev;
        logic [3:0] ei;
        ev = |eg;
        ei = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) ei = 4'(i);
        end
        n_cmp++;
        if (ag !== eg || av !== ev || ai !== ei) begin
            n_bad++;
            $display("FAIL %s: got g=%b valid=%b idx=%0d, want g=%b valid=%b idx=%0d",
                     tag, ag, av, ai, eg, ev, ei);
        end
    endtask

    task automatic drive_a(input logic [2:0] rv, input logic [2:0] eg, input string t);
        @(negedge clk);
        ra = rv;
        qa.push_back({1'b0, eg});
        ta.push_back(t);
    endtask

    task automatic drive_b(input logic [3:0] rv, input logic [3:0] eg, input string t);
        @(negedge clk);
        rb = rv;
        qb.push_back(eg);
        tbq.push_back(t);
    endtask

    task automatic drive_c(input logic [3:0] rv, input logic [3:0] eg, input string t);
        @(negedge clk);
        rc = rv;
        qc.push_back(eg);
        tc.push_back(t);
    endtask

    // Monitors: sample 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (qa.size() > 0) check(ta.pop_front(), {1'b0, ga}, va, {2'b00, ia}, qa.pop_front());
        if (qb.size() > 0) check(tbq.pop_front(), gb, vb, {2'b00, ib}, qb.pop_front());
        if (qc.size() > 0) check(tc.pop_front(), gc, vc, {2'b00, ic}, qc.pop_front());
    end

    initial begin
        resetn = 1'b0;
        ra = '0;
        rb = '0;
        rc = '0;
        #12;
        check("rst_a", {1'b0, ga}, va, {2'b00, ia}, 4'b0000);
        check("rst_b", gb, vb, {2'b00, ib}, 4'b0000);
        check("rst_c", gc, vc, {2'b00, ic}, 4'b0000);
        @(negedge clk);
        resetn = 1'b1;

        // Fixed priority, N=3: grant, no-bubble handover, idle.
        drive_a(3'b111, 3'b001, "fp_first");
        drive_a(3'b110, 3'b010, "fp_handover");
        drive_a(3'b000, 3'b000, "fp_idle");
        // Non-preemption.
        drive_a(3'b100, 3'b100, "np_grant2");
        drive_a(3'b110, 3'b100, "np_hold_110");
        drive_a(3'b101, 3'b100, "np_hold_101");
        drive_a(3'b001, 3'b001, "np_release");
        drive_a(3'b000, 3'b000, "np_idle");

        // Round-robin, N=4: each owner drops for a cycle, order 0,1,2,3,0.
        drive_b(4'b1111, 4'b0001, "rr_g0");
        drive_b(4'b1110, 4'b0010, "rr_g1");
        drive_b(4'b1101, 4'b0100, "rr_g2");
        drive_b(4'b1011, 4'b1000, "rr_g3");
        drive_b(4'b0111, 4'b0001, "rr_wrap_g0");
        drive_b(4'b0000, 4'b0000, "rr_idle");
        // Owner 3 releases with only requester 0 left.
        drive_b(4'b1000, 4'b1000, "rr_own3");
        drive_b(4'b0001, 4'b0001, "rr_3to0");
        drive_b(4'b0000, 4'b0000, "rr_idle2");
        // ptr is 1 here: requester 2 beats lower-indexed requester 0.
        drive_b(4'b0101, 4'b0100, "rr_ptr_skip0");

        // Asynchronous reset while requester 2 owns the grant.
        @(posedge clk);
        #3;
        resetn = 1'b0;
        rb = 4'bxxxx;
        #1;
        check("async_rst_b", gb, vb, {2'b00, ib}, 4'b0000);
        @(posedge clk);
        #3;
        resetn = 1'b1;
        drive_b(4'b0100, 4'b0100, "post_rst_grant");
        drive_b(4'b0000, 4'b0000, "post_rst_idle");

        // Two requesters held constant on the hold-limited instance.
        for (int k = 0; k < 12; k++) begin
`ifdef ARB_MAX_HOLD_EN
            drive_c(4'b0011, ((k / 4) == 1) ? 4'b0010 : 4'b0001, "hold_limit");
`else
            drive_c(4'b0011, 4'b0001, "hold_unlimited");
`endif
        end
        // A lone requester is never forced off.
        for (int k = 0; k < 6; k++) begin
            drive_c(4'b0001, 4'b0001, "hold_solo");
        end
        drive_c(4'b0000, 4'b0000, "hold_idle");

        repeat (3) @(negedge clk);
        n_cmp++;
        if (qa.size() + qb.size() + qc.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", qa.size() + qb.size() + qc.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
